// File: rtl/axi_writeback_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_writeback_master
//  Description : Write-direction AXI4 master. On a start pulse it streams
//                `length` words from the Output Buffer (starting at src_addr)
//                to DDR at dest_addr as INCR bursts. Bursts are capped at
//                MAX_BURST beats and never cross a 4 KB boundary. done_irq
//                pulses once the last B response has been received.
//                Optional performance counters: define AXI_WB_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_writeback_master #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_pulse,
    input  logic [AXI_ADDR_WIDTH-1:0] dest_addr,
    input  logic [ADDR_WIDTH-1:0]     src_addr,
    input  logic [15:0]               length,
    output logic                      done_irq,
    output logic                      busy,
    output logic                      bresp_err,
    output logic                      buf_rd_en,
    output logic [ADDR_WIDTH-1:0]     buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]     buf_rd_data,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [31:0]               perf_cycles,
    output logic [31:0]               perf_stalls
);

    localparam int          c_BYTES     = DATA_WIDTH / 8;
    localparam int          c_SIZE      = $clog2(c_BYTES);
    localparam logic [16:0] c_MAX_BURST = 17'(MAX_BURST);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_AW   = 3'd1;
    localparam logic [2:0] c_ST_W    = 3'd2;
    localparam logic [2:0] c_ST_B    = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    logic [2:0]                r_state;
    logic [2:0]                w_state_next;

    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [15:0]               r_remaining;
    logic [ADDR_WIDTH-1:0]     r_rd_addr;
    logic [8:0]                r_beats;
    logic [8:0]                r_fetch_left;
    logic [8:0]                r_send_left;
    logic                      r_inflight;
    logic                      r_bresp_err;

    logic [DATA_WIDTH-1:0]     r_fifo [2];
    logic [1:0]                r_cnt;
    logic                      r_wr_ptr;
    logic                      r_rd_ptr;

    logic                      w_start;
    logic                      w_aw_hs;
    logic                      w_b_hs;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_rd_en;
    logic [2:0]                w_occ;
    logic [16:0]               w_rem_ext;
    logic [16:0]               w_to_4k;
    logic [16:0]               w_beats;
    logic [15:0]               w_rem_after;

    assign w_start     = start_pulse && (r_state == c_ST_IDLE);
    assign w_aw_hs     = m_awvalid && m_awready;
    assign w_b_hs      = m_bvalid && m_bready;
    assign w_pop       = m_wvalid && m_wready;
    assign w_push      = r_inflight;
    assign w_rem_after = r_remaining - 16'(r_beats);

    // Occupancy is taken after this cycle's pop so a steady stream keeps one
    // word in the FIFO and one read in flight, sustaining 1 beat per cycle.
    assign w_occ   = {1'b0, r_cnt} - {2'b00, w_pop} + {2'b00, r_inflight};
    assign w_rd_en = (r_state == c_ST_W) && (r_fetch_left != 9'd0) && (w_occ < 3'd2);

    // Words left before the next 4 KB page; bounds the burst with remaining/MAX.
    assign w_rem_ext = {1'b0, r_remaining};
    assign w_to_4k   = {4'b0000, 13'h1000 - {1'b0, r_awaddr[11:0]}} >> c_SIZE;

    // Burst length = min(remaining, MAX_BURST, words to 4 KB boundary).
    always_comb begin
        w_beats = w_rem_ext;
        if (w_beats > c_MAX_BURST) begin
            w_beats = c_MAX_BURST;
        end
        if (w_beats > w_to_4k) begin
            w_beats = w_to_4k;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an empty job passes through AW without a request.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start_pulse) w_state_next = c_ST_AW;
            c_ST_AW: begin
                if (r_remaining == 16'd0) begin
                    w_state_next = c_ST_DONE;
                end else if (m_awready) begin
                    w_state_next = c_ST_W;
                end
            end
            c_ST_W: if (w_pop && (r_send_left == 9'd1)) w_state_next = c_ST_B;
            c_ST_B: begin
                if (m_bvalid) begin
                    w_state_next = (w_rem_after != 16'd0) ? c_ST_AW : c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy      = 1'b0;
        done_irq  = 1'b0;
        m_awvalid = 1'b0;
        m_awlen   = 8'd0;
        m_bready  = 1'b0;
        case (r_state)
            c_ST_AW: begin
                busy = 1'b1;
                if (r_remaining != 16'd0) begin
                    m_awvalid = 1'b1;
                    m_awlen   = w_beats[7:0] - 8'd1;
                end
            end
            c_ST_W: busy = 1'b1;
            c_ST_B: begin
                busy     = 1'b1;
                m_bready = 1'b1;
            end
            c_ST_DONE: begin
                busy     = 1'b1;
                done_irq = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_awaddr    = r_awaddr;
    assign m_awsize    = 3'(c_SIZE);
    assign m_awburst   = 2'b01;
    assign m_wvalid    = (r_cnt != 2'd0);
    assign m_wdata     = r_fifo[r_rd_ptr];
    assign m_wstrb     = {c_BYTES{m_wvalid}};
    assign m_wlast     = m_wvalid && (r_send_left == 9'd1);
    assign buf_rd_en   = w_rd_en;
    assign buf_rd_addr = r_rd_addr;
    assign bresp_err   = r_bresp_err;

    // Job registers, burst bookkeeping and read-address generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_awaddr     <= '0;
            r_remaining  <= 16'd0;
            r_rd_addr    <= '0;
            r_beats      <= 9'd0;
            r_fetch_left <= 9'd0;
            r_send_left  <= 9'd0;
            r_inflight   <= 1'b0;
            r_bresp_err  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_start) begin
                r_awaddr    <= dest_addr;
                r_remaining <= length;
                r_rd_addr   <= src_addr;
                r_bresp_err <= 1'b0;
            end
            if (w_aw_hs) begin
                r_beats      <= 9'(w_beats);
                r_fetch_left <= 9'(w_beats);
                r_send_left  <= 9'(w_beats);
            end
            if (w_rd_en) begin
                r_fetch_left <= r_fetch_left - 9'd1;
                r_rd_addr    <= r_rd_addr + 1'b1;
            end
            if (w_pop) begin
                r_send_left <= r_send_left - 9'd1;
            end
            if (w_b_hs) begin
                if (m_bresp != 2'b00) begin
                    r_bresp_err <= 1'b1;
                end
                r_awaddr    <= r_awaddr + (AXI_ADDR_WIDTH'(r_beats) << c_SIZE);
                r_remaining <= w_rem_after;
            end
        end
    end

    // Two-entry skid FIFO between the buffer read port and the W channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_cnt     <= 2'd0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= buf_rd_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef AXI_WB_PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    // Saturating job-cycle and W-stall counters, cleared on accepted start.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_perf_cycles <= 32'd0;
            r_perf_stalls <= 32'd0;
        end else begin
            if (busy && (r_perf_cycles != 32'hFFFF_FFFF)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (m_wvalid && !m_wready && (r_perf_stalls != 32'hFFFF_FFFF)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`else
    assign perf_cycles = 32'd0;
    assign perf_stalls = 32'd0;
`endif

endmodule
`default_nettype wire
